// File: rtl/aemb2_dwb_ctrl.sv
// AEMB2 data Wishbone controller: posted write buffer, big-endian lane steering,
// partial-word load extraction, misalignment rejection and a bus timeout.
module aemb2_dwb_ctrl #(
   parameter int AEMB_DWB   = 32,
   parameter int WBUF_DEPTH = 4,
   parameter int TMO_CYC    = 255
) (
   input  logic                gclk,
   input  logic                grst,
   input  logic                req_stb,
   output logic                req_rdy,
   input  logic                req_wre,
   input  logic [1:0]          req_siz,
   input  logic                req_sgn,
   input  logic [AEMB_DWB-1:0] req_adr,
   input  logic [31:0]         req_dat,
   output logic                rsp_vld,
   output logic [31:0]         rsp_dat,
   output logic                rsp_err,
   output logic                wr_err,
   input  logic                msr_dce,
   output logic [AEMB_DWB-3:0] dwb_adr_o,
   output logic [3:0]          dwb_sel_o,
   output logic                dwb_stb_o,
   output logic                dwb_cyc_o,
   output logic                dwb_wre_o,
   output logic                dwb_tag_o,
   output logic [31:0]         dwb_dat_o,
   input  logic [31:0]         dwb_dat_i,
   input  logic                dwb_ack_i
);

   localparam int AW   = $clog2(WBUF_DEPTH);
   localparam int PW   = AW + 1;
   localparam int BW   = AEMB_DWB - 2;
   localparam int EW   = BW + 4 + 32;
   localparam int TW   = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
   localparam int TLIM = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;

   // Handshake: a request transfers on a rising edge where req_stb && req_rdy;
   // the bus side transfers on a rising edge where dwb_stb_o && dwb_ack_i.
   typedef enum logic [1:0] {IDLE, WR, RD} state_t;
   state_t state, state_d;

   logic [1:0]  off;
   logic [3:0]  lsel;
   logic [31:0] ldat;
   logic        lok;

   always_comb begin
      off  = req_adr[1:0];
      lsel = 4'h0;
      ldat = req_dat;
      lok  = 1'b0;
      case (req_siz)
         2'd0: begin
            lok  = 1'b1;
            ldat = {4{req_dat[7:0]}};
            case (off)
               2'd0:    lsel = 4'h8;
               2'd1:    lsel = 4'h4;
               2'd2:    lsel = 4'h2;
               default: lsel = 4'h1;
            endcase
         end
         2'd1: begin
            lok  = !off[0];
            ldat = {2{req_dat[15:0]}};
            lsel = off[1] ? 4'h3 : 4'hC;
         end
         2'd2: begin
            lok  = (off == 2'd0);
            lsel = 4'hF;
         end
         default: lok = 1'b0;
      endcase
   end

   logic [EW-1:0] mem [WBUF_DEPTH];
   logic [PW-1:0] wp, rp;
   logic          fifo_empty, fifo_full;
   logic [EW-1:0] head;
   logic          load_pend;
   logic          acc, push, pop;

   assign fifo_empty = (wp == rp);
   assign fifo_full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign head       = mem[rp[AW-1:0]];

   assign req_rdy = grst & !load_pend & (req_wre ? !fifo_full : 1'b1);
   assign acc     = req_stb & req_rdy;
   assign push    = acc & req_wre & lok;

   logic [BW-1:0] hld_adr;
   logic [3:0]    hld_sel;
   logic          hld_sgn;

   function automatic logic [31:0] extract(input logic [31:0] d, input logic [3:0] s,
                                           input logic sg);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[7:0];
      h = d[15:0];
      case (s)
         4'h8:    b = d[31:24];
         4'h4:    b = d[23:16];
         4'h2:    b = d[15:8];
         4'hC:    h = d[31:16];
         default: ;
      endcase
      case (s)
         4'h8, 4'h4, 4'h2, 4'h1: extract = {{24{sg & b[7]}}, b};
         4'hC, 4'h3:             extract = {{16{sg & h[15]}}, h};
         default:                extract = d;
      endcase
   endfunction

   logic [TW-1:0] cnt, cnt_d;
   logic          tmo_hit;
   logic          stb_d, wre_d, rsp_vld_d, rsp_err_d, wr_err_d, pend_clr;
   logic [BW-1:0] adr_d;
   logic [3:0]    sel_d;
   logic [31:0]   dat_d, rsp_dat_d;

   // An ack in the final cycle beats the timeout.
   assign tmo_hit = (TMO_CYC != 0) && !dwb_ack_i && (cnt == TW'(TLIM));

   always_comb begin
      state_d   = state;
      stb_d     = dwb_stb_o;
      adr_d     = dwb_adr_o;
      sel_d     = dwb_sel_o;
      wre_d     = dwb_wre_o;
      dat_d     = dwb_dat_o;
      cnt_d     = cnt;
      pop       = 1'b0;
      pend_clr  = 1'b0;
      rsp_vld_d = 1'b0;
      rsp_err_d = 1'b0;
      rsp_dat_d = rsp_dat;
      wr_err_d  = 1'b0;
      case (state)
         IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               state_d = WR;
               stb_d   = 1'b1;
               adr_d   = head[EW-1 -: BW];
               sel_d   = head[35:32];
               dat_d   = head[31:0];
               wre_d   = 1'b1;
            end else if (load_pend) begin
               state_d = RD;
               stb_d   = 1'b1;
               adr_d   = hld_adr;
               sel_d   = hld_sel;
               dat_d   = 32'h0;
               wre_d   = 1'b0;
            end
         end
         WR: begin
            if (dwb_ack_i || tmo_hit) begin
               pop      = 1'b1;
               stb_d    = 1'b0;
               state_d  = IDLE;
               cnt_d    = '0;
               wr_err_d = !dwb_ack_i;
            end else begin
               cnt_d = cnt + TW'(1);
            end
         end
         RD: begin
            if (dwb_ack_i || tmo_hit) begin
               pend_clr  = 1'b1;
               stb_d     = 1'b0;
               state_d   = IDLE;
               cnt_d     = '0;
               rsp_vld_d = 1'b1;
               rsp_err_d = !dwb_ack_i;
               rsp_dat_d = dwb_ack_i ? extract(dwb_dat_i, hld_sel, hld_sgn) : 32'h0;
            end else begin
               cnt_d = cnt + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            stb_d   = 1'b0;
         end
      endcase
      // Rejected requests never collide with a load completion: load_pend blocks them.
      if (acc && !lok) begin
         if (req_wre) begin
            wr_err_d = 1'b1;
         end else begin
            rsp_vld_d = 1'b1;
            rsp_err_d = 1'b1;
            rsp_dat_d = 32'h0;
         end
      end
   end

   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         state     <= IDLE;
         dwb_stb_o <= 1'b0;
         dwb_adr_o <= '0;
         dwb_sel_o <= 4'h0;
         dwb_wre_o <= 1'b0;
         dwb_dat_o <= 32'h0;
         cnt       <= '0;
         rsp_vld   <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_dat   <= 32'h0;
         wr_err    <= 1'b0;
      end else begin
         state     <= state_d;
         dwb_stb_o <= stb_d;
         dwb_adr_o <= adr_d;
         dwb_sel_o <= sel_d;
         dwb_wre_o <= wre_d;
         dwb_dat_o <= dat_d;
         cnt       <= cnt_d;
         rsp_vld   <= rsp_vld_d;
         rsp_err   <= rsp_err_d;
         rsp_dat   <= rsp_dat_d;
         wr_err    <= wr_err_d;
      end
   end

   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         wp        <= '0;
         rp        <= '0;
         load_pend <= 1'b0;
         hld_adr   <= '0;
         hld_sel   <= 4'h0;
         hld_sgn   <= 1'b0;
      end else begin
         if (push) wp <= wp + PW'(1);
         if (pop)  rp <= rp + PW'(1);
         if (pend_clr) begin
            load_pend <= 1'b0;
         end else if (acc && !req_wre && lok) begin
            load_pend <= 1'b1;
            hld_adr   <= req_adr[AEMB_DWB-1:2];
            hld_sel   <= lsel;
            hld_sgn   <= req_sgn;
         end
      end
   end

   always_ff @(posedge gclk) begin
      if (push) mem[wp[AW-1:0]] <= {req_adr[AEMB_DWB-1:2], lsel, ldat};
   end

   assign dwb_cyc_o = dwb_stb_o;
   assign dwb_tag_o = msr_dce;

endmodule

// File: tb/tb_aemb2_dwb_ctrl.sv
// Directed bench for aemb2_dwb_ctrl: one default instance plus one with a
// short timeout, both driven from the same request/bus stimulus.
module tb_aemb2_dwb_ctrl;
   logic        gclk, grst;
   logic        req_stb, req_wre, req_sgn, msr_dce, ack;
   logic [1:0]  req_siz;
   logic [31:0] req_adr, req_dat, dat_i;

   logic        o_rdy, o_vld, o_err, o_werr, o_stb, o_cyc, o_wre, o_tag;
   logic [31:0] o_rdat, o_dat;
   logic [29:0] o_adr;
   logic [3:0]  o_sel;
   logic        t_rdy, t_vld, t_err, t_werr, t_stb, t_cyc, t_wre, t_tag;
   logic [31:0] t_rdat, t_dat;
   logic [29:0] t_adr;
   logic [3:0]  t_sel;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   aemb2_dwb_ctrl dut (
      .gclk(gclk), .grst(grst), .req_stb(req_stb), .req_rdy(o_rdy), .req_wre(req_wre),
      .req_siz(req_siz), .req_sgn(req_sgn), .req_adr(req_adr), .req_dat(req_dat),
      .rsp_vld(o_vld), .rsp_dat(o_rdat), .rsp_err(o_err), .wr_err(o_werr),
      .msr_dce(msr_dce), .dwb_adr_o(o_adr), .dwb_sel_o(o_sel), .dwb_stb_o(o_stb),
      .dwb_cyc_o(o_cyc), .dwb_wre_o(o_wre), .dwb_tag_o(o_tag), .dwb_dat_o(o_dat),
      .dwb_dat_i(dat_i), .dwb_ack_i(ack)
   );

   aemb2_dwb_ctrl #(.TMO_CYC(4)) dut_t (
      .gclk(gclk), .grst(grst), .req_stb(req_stb), .req_rdy(t_rdy), .req_wre(req_wre),
      .req_siz(req_siz), .req_sgn(req_sgn), .req_adr(req_adr), .req_dat(req_dat),
      .rsp_vld(t_vld), .rsp_dat(t_rdat), .rsp_err(t_err), .wr_err(t_werr),
      .msr_dce(msr_dce), .dwb_adr_o(t_adr), .dwb_sel_o(t_sel), .dwb_stb_o(t_stb),
      .dwb_cyc_o(t_cyc), .dwb_wre_o(t_wre), .dwb_tag_o(t_tag), .dwb_dat_o(t_dat),
      .dwb_dat_i(dat_i), .dwb_ack_i(ack)
   );

   // clock / reset
   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   task automatic do_reset();
      req_stb = 0; req_wre = 0; req_siz = 0; req_sgn = 0; req_adr = 0; req_dat = 0;
      ack = 0; dat_i = 0;
      grst = 1'b0;
      repeat (2) @(posedge gclk);
      #1 grst = 1'b1;
      @(posedge gclk); #1;
   endtask

   // driver: present one request for one cycle; returns at the next sample point
   task automatic issue(input bit wre, input logic [1:0] siz, input bit sgn,
                        input logic [31:0] adr, input logic [31:0] dat);
      req_stb = 1; req_wre = wre; req_siz = siz; req_sgn = sgn; req_adr = adr; req_dat = dat;
      @(posedge gclk); #1;
      req_stb = 0;
   endtask

   task automatic wait_stb(input bit which, input int max, output bit ok);
      ok = 0;
      for (int i = 0; i < max; i++) begin
         if ((which ? t_stb : o_stb) === 1'b1) begin ok = 1; break; end
         @(posedge gclk); #1;
      end
   endtask

   task automatic test_reset();
      msr_dce = 1'b1;
      grst = 1'b1; #1 grst = 1'b0; #1;
      n_chk++;
      if ({o_stb, o_cyc, o_wre, o_sel, o_adr, o_dat} !== 68'h0) begin
         n_fail++; $display("FAIL reset_bus: got stb=%b sel=%h adr=%h dat=%h expected all 0", o_stb, o_sel, o_adr, o_dat);
      end
      n_chk++;
      if ({o_rdy, o_vld, o_err, o_werr, o_rdat} !== 36'h0) begin
         n_fail++; $display("FAIL reset_rsp: got rdy=%b vld=%b err=%b werr=%b rdat=%h expected 0", o_rdy, o_vld, o_err, o_werr, o_rdat);
      end
      n_chk++;
      if (o_tag !== 1'b1) begin n_fail++; $display("FAIL reset_tag: got %b expected 1", o_tag); end
      do_reset();
      msr_dce = 1'b0; #1;
      n_chk++;
      if ({o_rdy, o_tag} !== 2'b10) begin n_fail++; $display("FAIL post_reset_rdy_tag: got %b expected 10", {o_rdy, o_tag}); end
   endtask

   task automatic test_store_word();
      do_reset();
      issue(1, 2'd2, 0, 32'h100, 32'hDEADBEEF);
      n_chk++;
      if (o_stb !== 1'b0) begin n_fail++; $display("FAIL store_lat1: got stb=%b expected 0", o_stb); end
      @(posedge gclk); #1;
      n_chk++;
      if ({o_stb, o_cyc, o_wre, o_sel, o_adr, o_dat} !== {3'b111, 4'hF, 30'h40, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL store_word_bus: got stb=%b wre=%b sel=%h adr=%h dat=%h expected 1 1 f 40 deadbeef", o_stb, o_wre, o_sel, o_adr, o_dat);
      end
      ack = 1; @(posedge gclk); #1; ack = 0;
      n_chk++;
      if ({o_stb, o_vld, o_werr} !== 3'b000) begin n_fail++; $display("FAIL store_word_done: got stb/vld/werr=%b expected 000", {o_stb, o_vld, o_werr}); end
   endtask

   task automatic test_store_lanes();
      logic [31:0] a[4] = '{32'h103, 32'h102, 32'h100, 32'h100};
      logic [1:0]  s[4] = '{2'd0, 2'd1, 2'd0, 2'd1};
      logic [31:0] d[4] = '{32'h5A, 32'h1234, 32'h77, 32'hABCD};
      logic [3:0]  es[4] = '{4'h1, 4'h3, 4'h8, 4'hC};
      logic [31:0] ed[4] = '{32'h5A5A5A5A, 32'h12341234, 32'h77777777, 32'hABCDABCD};
      bit ok;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         issue(1, s[i], 0, a[i], d[i]);
         wait_stb(0, 6, ok);
         n_chk++;
         if (!ok || {o_sel, o_dat, o_adr, o_wre} !== {es[i], ed[i], 30'h40, 1'b1}) begin
            n_fail++; $display("FAIL store_lane%0d: got stb=%b sel=%h dat=%h adr=%h expected sel=%h dat=%h adr=40", i, o_stb, o_sel, o_dat, o_adr, es[i], ed[i]);
         end
         ack = 1; @(posedge gclk); #1; ack = 0;
      end
   endtask

   task automatic test_load_extend();
      logic [31:0] a[3]  = '{32'h101, 32'h101, 32'h102};
      logic [1:0]  s[3]  = '{2'd0, 2'd0, 2'd1};
      logic        g[3]  = '{1'b1, 1'b0, 1'b1};
      logic [31:0] bd[3] = '{32'h0080FFFF, 32'h0080FFFF, 32'h00008001};
      logic [3:0]  es[3] = '{4'h4, 4'h4, 4'h3};
      logic [31:0] er[3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         issue(0, s[i], g[i], a[i], 32'h0);
         n_chk++;
         if ({o_rdy, o_stb} !== 2'b00) begin n_fail++; $display("FAIL load%0d_pend: got rdy/stb=%b expected 00", i, {o_rdy, o_stb}); end
         @(posedge gclk); #1;
         n_chk++;
         if ({o_stb, o_wre, o_sel, o_adr} !== {2'b10, es[i], 30'h40}) begin
            n_fail++; $display("FAIL load%0d_bus: got stb=%b wre=%b sel=%h adr=%h expected 1 0 %h 40", i, o_stb, o_wre, o_sel, o_adr, es[i]);
         end
         dat_i = bd[i]; ack = 1; @(posedge gclk); #1; ack = 0;
         n_chk++;
         if ({o_vld, o_err, o_rdat, o_stb, o_rdy} !== {2'b10, er[i], 2'b01}) begin
            n_fail++; $display("FAIL load%0d_rsp: got vld=%b err=%b dat=%h stb=%b rdy=%b expected 1 0 %h 0 1", i, o_vld, o_err, o_rdat, o_stb, o_rdy, er[i]);
         end
         @(posedge gclk); #1;
         n_chk++;
         if (o_vld !== 1'b0) begin n_fail++; $display("FAIL load%0d_pulse: got vld=%b expected 0", i, o_vld); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [31:0] exp;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         issue(1, 2'd2, 0, 32'h200 + 32'(i * 4), 32'h11111111 * (i + 1));
         exp_q.push_back({2'b10, 30'h80 + 30'(i)});
      end
      req_stb = 1; req_wre = 1; req_siz = 2'd2; req_adr = 32'h210; #1;
      n_chk++;
      if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL fifo_full_rdy: got %b expected 0", o_rdy); end
      req_wre = 0; req_adr = 32'h300; #1;
      n_chk++;
      if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL load_behind_rdy: got %b expected 1", o_rdy); end
      @(posedge gclk); #1; req_stb = 0;
      exp_q.push_back({2'b00, 30'hC0});
      for (int i = 0; i < 5; i++) begin
         wait_stb(0, 8, ok);
         exp = exp_q.pop_front();
         n_chk++;
         if (!ok || {o_wre, 1'b0, o_adr} !== exp) begin
            n_fail++; $display("FAIL order%0d: got stb=%b {wre,adr}=%h expected %h", i, o_stb, {o_wre, 1'b0, o_adr}, exp);
         end
         if (i == 4) dat_i = 32'hCAFEF00D;
         ack = 1; @(posedge gclk); #1; ack = 0;
      end
      n_chk++;
      if ({o_vld, o_err, o_rdat} !== {2'b10, 32'hCAFEF00D}) begin
         n_fail++; $display("FAIL order_load_rsp: got vld=%b err=%b dat=%h expected 1 0 cafef00d", o_vld, o_err, o_rdat);
      end
   endtask

   task automatic test_misaligned();
      bit ok;
      // rsp_dat still holds the previous load value here, so the zero is meaningful
      issue(0, 2'd1, 0, 32'h101, 32'h0);
      n_chk++;
      if ({o_vld, o_err, o_rdat, o_stb, o_rdy} !== {2'b11, 32'h0, 2'b01}) begin
         n_fail++; $display("FAIL mis_load: got vld=%b err=%b dat=%h stb=%b rdy=%b expected 1 1 0 0 1", o_vld, o_err, o_rdat, o_stb, o_rdy);
      end
      issue(1, 2'd2, 0, 32'h102, 32'h55555555);
      n_chk++;
      if ({o_werr, o_vld} !== 2'b10) begin n_fail++; $display("FAIL mis_store_werr: got werr/vld=%b expected 10", {o_werr, o_vld}); end
      issue(1, 2'd3, 0, 32'h100, 32'h66666666);
      n_chk++;
      if (o_werr !== 1'b1) begin n_fail++; $display("FAIL siz3_werr: got %b expected 1", o_werr); end
      @(posedge gclk); #1;
      n_chk++;
      if (o_werr !== 1'b0) begin n_fail++; $display("FAIL werr_pulse: got %b expected 0", o_werr); end
      wait_stb(0, 5, ok);
      n_chk++;
      if (ok) begin n_fail++; $display("FAIL mis_no_enqueue: got stb=1 expected 0"); end
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      do_reset();
      issue(0, 2'd2, 0, 32'h400, 32'h0);
      wait_stb(1, 6, ok);
      n = 0;
      while (t_stb === 1'b1 && n < 20) begin n++; @(posedge gclk); #1; end
      n_chk++;
      if (!ok || n != 4) begin n_fail++; $display("FAIL tmo_load_len: got %0d stb cycles expected 4", n); end
      n_chk++;
      if ({t_vld, t_err, t_rdat} !== {2'b11, 32'h0}) begin
         n_fail++; $display("FAIL tmo_load_rsp: got vld=%b err=%b dat=%h expected 1 1 0", t_vld, t_err, t_rdat);
      end
      issue(1, 2'd2, 0, 32'h404, 32'h12345678);
      wait_stb(1, 6, ok);
      n = 0;
      while (t_stb === 1'b1 && n < 20) begin n++; @(posedge gclk); #1; end
      n_chk++;
      if (!ok || n != 4 || {t_werr, t_vld} !== 2'b10) begin
         n_fail++; $display("FAIL tmo_store: got %0d cycles werr=%b vld=%b expected 4 1 0", n, t_werr, t_vld);
      end
      issue(0, 2'd2, 0, 32'h408, 32'h0);
      wait_stb(1, 6, ok);
      repeat (3) begin @(posedge gclk); #1; end
      dat_i = 32'h13572468; ack = 1; @(posedge gclk); #1; ack = 0;
      n_chk++;
      if (!ok || {t_vld, t_err, t_rdat} !== {2'b10, 32'h13572468}) begin
         n_fail++; $display("FAIL tmo_ack_wins: got vld=%b err=%b dat=%h expected 1 0 13572468", t_vld, t_err, t_rdat);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      issue(1, 2'd2, 0, 32'h500, 32'hA5A5A5A5);
      issue(1, 2'd2, 0, 32'h504, 32'h5A5A5A5A);
      wait_stb(0, 6, ok);
      #2 grst = 1'b0; #1;
      n_chk++;
      if (!ok || {o_stb, o_cyc} !== 2'b00) begin n_fail++; $display("FAIL reset_mid_stb: got stb/cyc=%b expected 00", {o_stb, o_cyc}); end
      @(posedge gclk); #1 grst = 1'b1;
      @(posedge gclk); #1;
      issue(0, 2'd2, 0, 32'h600, 32'h0);
      wait_stb(0, 6, ok);
      n_chk++;
      if (!ok || {o_wre, o_adr} !== {1'b0, 30'h180}) begin
         n_fail++; $display("FAIL reset_mid_fifo: got stb=%b wre=%b adr=%h expected 1 0 180", o_stb, o_wre, o_adr);
      end
      ack = 1; @(posedge gclk); #1; ack = 0;
   endtask

   initial begin
      grst = 1'b1; msr_dce = 1'b0;
      req_stb = 0; req_wre = 0; req_siz = 0; req_sgn = 0; req_adr = 0; req_dat = 0;
      ack = 0; dat_i = 0;
      @(posedge gclk); #1;
      test_reset();
      test_store_word();
      test_store_lanes();
      test_load_extend();
      test_back_to_back();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
